// File: rtl/cbd_reload_down_counter_if.sv
// Control/data bundle for the reload down counter: the driver side is master and the
// counter itself is slave.
interface cbd_reload_down_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             sd;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             rld_we;
    logic             start;
    logic             mode;
    logic             en;
    logic             bi;
    logic [WIDTH-1:0] q;
    logic             bo;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output sd, ld, d, rld_we, start, mode, en, bi,
        input  q, bo, tc, busy, done
    );

    modport slave (
        input  sd, ld, d, rld_we, start, mode, en, bi,
        output q, bo, tc, busy, done
    );
endinterface

// File: rtl/cbd_reload_down_counter.sv
// Cascadable down counter/timer with borrow chain, parallel load, auto-reload register
// and a one-shot/periodic run sequencer.
module cbd_reload_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input logic                         clk_i,
    input logic                         cd_i,
    cbd_reload_down_counter_if.slave    bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    logic             busy;
    logic             dec;
    logic             q_zero;

    assign busy   = (state_q == StRun);
    assign dec    = busy & bus.bi & bus.en;
    assign q_zero = (q_q == '0);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;

        if (bus.rld_we) begin
            rld_d = bus.d;
        end

        // Reload paths read rld_q, so a same-cycle RLD write only affects the next reload.
        if (bus.sd) begin
            q_d = '1;
        end else if (bus.ld) begin
            q_d = bus.d;
        end else if (bus.start) begin
            q_d     = rld_q;
            state_d = StRun;
        end else if (dec) begin
            if (!q_zero) begin
                q_d = q_q - 1'b1;
            end else begin
                tc_d = 1'b1;
                if (bus.mode) begin
                    q_d = rld_q;
                end else begin
                    state_d = StDone;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cd_i) begin
            state_q <= StIdle;
            q_q     <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.tc   = tc_q;
    assign bus.busy = busy;
    assign bus.done = (state_q == StDone);
    assign bus.bo   = dec & q_zero;

endmodule

// File: tb/tb_cbd_reload_down_counter.sv
// Scoreboard bench: a single stage walked through hand-derived sequences, then a
// two-stage cascade checked for upper-stage stepping and combined TC period.
module tb_cbd_reload_down_counter;

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic cd  = 1'b0;
    logic cd_c = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [3:0] hi_sb[$];

    always #5 clk = ~clk;

    cbd_reload_down_counter_if #(.WIDTH(4)) s_if ();
    cbd_reload_down_counter_if #(.WIDTH(4)) lo_if ();
    cbd_reload_down_counter_if #(.WIDTH(4)) hi_if ();

    assign hi_if.bi = lo_if.bo;

    cbd_reload_down_counter #(.WIDTH(4)) u_dut (
        .clk_i (clk),
        .cd_i  (cd),
        .bus   (s_if.slave)
    );

    cbd_reload_down_counter #(.WIDTH(4)) u_lo (
        .clk_i (clk),
        .cd_i  (cd_c),
        .bus   (lo_if.slave)
    );

    cbd_reload_down_counter #(.WIDTH(4)) u_hi (
        .clk_i (clk),
        .cd_i  (cd_c),
        .bus   (hi_if.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // BO is combinational, so it is checked before the edge; registered outputs after.
    task automatic step(input logic [3:0] eq, input logic etc, input logic ebusy,
                        input logic edone, input logic ebo);
        exp_t e;
        check_val("bo", {31'd0, s_if.bo}, {31'd0, ebo});
        sb.push_back('{q: eq, tc: etc, busy: ebusy, done: edone});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("q", {28'd0, s_if.q}, {28'd0, e.q});
        check_val("tc", {31'd0, s_if.tc}, {31'd0, e.tc});
        check_val("busy", {31'd0, s_if.busy}, {31'd0, e.busy});
        check_val("done", {31'd0, s_if.done}, {31'd0, e.done});
    endtask

    task automatic pulses_off();
        s_if.sd = 1'b0; s_if.ld = 1'b0; s_if.rld_we = 1'b0; s_if.start = 1'b0;
    endtask

    initial begin
        int tc_idx[$];
        logic [3:0] eh;
        int gap;

        pulses_off();
        s_if.d = 4'h0; s_if.mode = 1'b1; s_if.en = 1'b1; s_if.bi = 1'b1;
        lo_if.sd = 1'b0; lo_if.ld = 1'b0; lo_if.rld_we = 1'b0; lo_if.start = 1'b0;
        hi_if.sd = 1'b0; hi_if.ld = 1'b0; hi_if.rld_we = 1'b0; hi_if.start = 1'b0;
        lo_if.d = 4'h0; hi_if.d = 4'h0; lo_if.mode = 1'b1; hi_if.mode = 1'b1;
        lo_if.en = 1'b1; hi_if.en = 1'b1; lo_if.bi = 1'b1;

        // Reset
        cd = 1'b1; cd_c = 1'b1;
        @(posedge clk); #1;
        step(4'h0, 0, 0, 0, 0);
        cd = 1'b0;

        // Periodic, RLD=3
        s_if.rld_we = 1'b1; s_if.d = 4'h3;
        step(4'h0, 0, 0, 0, 0);
        pulses_off(); s_if.start = 1'b1;
        step(4'h3, 0, 1, 0, 0);
        pulses_off();
        step(4'h2, 0, 1, 0, 0);
        step(4'h1, 0, 1, 0, 0);
        step(4'h0, 0, 1, 0, 0);
        step(4'h3, 1, 1, 0, 1);
        step(4'h2, 0, 1, 0, 0);
        step(4'h1, 0, 1, 0, 0);
        step(4'h0, 0, 1, 0, 0);
        step(4'h3, 1, 1, 0, 1);

        // One-shot, RLD=2; EN=0 holds Q meanwhile
        s_if.en = 1'b0; s_if.mode = 1'b0; s_if.rld_we = 1'b1; s_if.d = 4'h2;
        step(4'h3, 0, 1, 0, 0);
        pulses_off(); s_if.start = 1'b1;
        step(4'h2, 0, 1, 0, 0);
        pulses_off(); s_if.en = 1'b1;
        step(4'h1, 0, 1, 0, 0);
        step(4'h0, 0, 1, 0, 0);
        step(4'h0, 1, 0, 1, 1);
        step(4'h0, 0, 0, 1, 0);
        s_if.ld = 1'b1; s_if.d = 4'h9;
        step(4'h9, 0, 0, 1, 0);
        pulses_off();
        step(4'h9, 0, 0, 1, 0);
        s_if.start = 1'b1;
        step(4'h2, 0, 1, 0, 0);
        pulses_off(); s_if.bi = 1'b0;
        step(4'h2, 0, 1, 0, 0);
        s_if.bi = 1'b1; s_if.mode = 1'b1;

        // LD beats a zero event; RLD write alongside a reload
        step(4'h1, 0, 1, 0, 0);
        step(4'h0, 0, 1, 0, 0);
        s_if.ld = 1'b1; s_if.d = 4'h5;
        step(4'h5, 0, 1, 0, 1);
        pulses_off();
        for (int i = 4; i >= 0; i--) step(4'(i), 0, 1, 0, 0);
        s_if.rld_we = 1'b1; s_if.d = 4'h7;
        step(4'h2, 1, 1, 0, 1);
        pulses_off();
        step(4'h1, 0, 1, 0, 0);
        step(4'h0, 0, 1, 0, 0);
        step(4'h7, 1, 1, 0, 1);

        // CD mid-count clears Q and RLD
        for (int i = 6; i >= 2; i--) step(4'(i), 0, 1, 0, 0);
        cd = 1'b1;
        step(4'h0, 0, 0, 0, 0);
        cd = 1'b0; s_if.start = 1'b1;
        step(4'h0, 0, 1, 0, 0);
        pulses_off();
        // RLD=0: zero event every DEC cycle
        step(4'h0, 1, 1, 0, 1);
        step(4'h0, 1, 1, 0, 1);
        s_if.mode = 1'b0;
        step(4'h0, 1, 0, 1, 1);
        s_if.sd = 1'b1;
        step(4'hF, 0, 0, 1, 0);
        pulses_off(); s_if.rld_we = 1'b1; s_if.d = 4'h6;
        step(4'hF, 0, 0, 1, 0);
        pulses_off(); s_if.start = 1'b1;
        step(4'h6, 0, 1, 0, 0);
        pulses_off();
        step(4'h5, 0, 1, 0, 0);
        s_if.start = 1'b1;
        step(4'h6, 0, 1, 0, 0);
        pulses_off();

        // Two-stage cascade, RLD=F/F periodic
        cd_c = 1'b0;
        lo_if.rld_we = 1'b1; hi_if.rld_we = 1'b1; lo_if.d = 4'hF; hi_if.d = 4'hF;
        @(posedge clk); #1;
        lo_if.rld_we = 1'b0; hi_if.rld_we = 1'b0;
        lo_if.start = 1'b1; hi_if.start = 1'b1;
        @(posedge clk); #1;
        lo_if.start = 1'b0; hi_if.start = 1'b0;
        check_val("lo_start", {28'd0, lo_if.q}, 32'hF);
        check_val("hi_start", {28'd0, hi_if.q}, 32'hF);
        for (int c = 0; c < 600; c++) begin
            if (lo_if.bo) eh = (hi_if.q == 4'h0) ? 4'hF : hi_if.q - 4'h1;
            else eh = hi_if.q;
            hi_sb.push_back(eh);
            @(posedge clk); #1;
            if (c % 8 == 0 || lo_if.q == 4'hF) begin
                check_val("hi_q", {28'd0, hi_if.q}, {28'd0, hi_sb[0]});
            end
            void'(hi_sb.pop_front());
            if (hi_if.tc) tc_idx.push_back(c);
        end
        gap = (tc_idx.size() >= 2) ? tc_idx[1] - tc_idx[0] : 0;
        check_val("hi_tc_period", gap, 256);
        check_val("hi_tc_first", (tc_idx.size() >= 1) ? tc_idx[0] : -1, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
